data_sram_resp: RTL and testbench
=================================

// Module: data_sram_resp
// PURPOSE
//  Responder end of the CPU data-SRAM port. Serves loads and stores issued by EX (en/wen/addr/wdata).
//  Returns the full aligned word on data_sram_rdata for MEM to byte/half-select and extend.
//  Single-port, word-organised, byte-write RAM with registered read data.
//  Optional wait-state engine raises stallreq for slow-memory emulation.
// PARAMETERS
//  ADDR_W       10  word-address bits; DEPTH = 2**ADDR_W words
//  WAIT_CYCLES  2   wait states per access (>=1); used only with DSRAM_WAIT_EN
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  data_sram_en     in   1   access request
//  data_sram_wen    in   4   byte write enables; 4'b0000 = read
//  data_sram_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  data_sram_wdata  in   32  store data, lane-aligned by EX
//  data_sram_rdata  out  32  registered read word
//  stallreq         out  1   hold-pipeline request to the stall controller
// BEHAVIOUR
//  - Reset: data_sram_rdata=0, stallreq=0, FSM=IDLE, counter=0. RAM contents are not reset.
//  - Address: addr[1:0] ignored (MEM selects lanes). Bits above ADDR_W+1 ignored, so addresses wrap.
//  - Write (en=1, wen!=0): lane i (wen[i] -> bits 8i+7:8i) written at the access edge.
//    Unselected lanes are untouched. rdata is unchanged by a write.
//  - Read (en=1, wen=0): rdata <= mem[idx] at the access edge; valid the next cycle.
//    rdata holds until the next completed read.
//  - Read in the cycle after a write to the same word returns the new bytes (no stale forwarding path).
//  - en=0: no RAM access, rdata held.
//  - Zero-wait mode (macro undefined): the access edge is the edge ending the request cycle.
//    stallreq is constant 0. No FSM.
// CONFIGURATION
//  Macro DSRAM_WAIT_EN.
//  - Defined: FSM IDLE/WAIT/DONE with counter cnt[$clog2(WAIT_CYCLES+1)-1:0].
//    IDLE: if en, stallreq=1 (combinational, same cycle); latch wen/idx/wdata;
//      cnt<=WAIT_CYCLES-1; go WAIT.
//    WAIT: stallreq=1. If cnt!=0, cnt--. If cnt==0, perform the latched access
//      (write lanes / load rdata); go DONE.
//    DONE: stallreq=0. The pipeline releases the held request this cycle; en is ignored; go IDLE.
//    Total stall = WAIT_CYCLES+1 cycles per access. Latched request is used, not live bus values.
//  - Reset mid-WAIT: pending access discarded (no RAM write), FSM=IDLE, rdata=0.
//  - Undefined: behaviour as in zero-wait mode above.
// STRUCTURE
//  - Shared package dsram_pkg: FSM state encodings (ST_IDLE, ST_WAIT, ST_DONE).
//    Also the lane-width constant BYTE_W=8 and the read-code constant WEN_READ=4'b0000.
//  - Sub-module dsram_byte_lane: one 8-bit x DEPTH synchronous RAM with we/addr/din/dout.
//    Instantiated 4x, one per lane; the top holds the FSM, request latch and rdata register.
// TESTING
//  1. Store: wen=1111 addr=0x10 wdata=0xA1B2C3D4, then read 0x10 -> rdata=0xA1B2C3D4 next cycle.
//  2. Partial store: wen=0100 addr=0x12 wdata=0x00EE0000 on word 0x10, then read 0x10
//     -> 0xA1EEC3D4; other lanes intact.
//  3. Wrap (ADDR_W=10): write 0x5 to 0x1000, then read 0x0000 -> 0x00000005;
//     read of 0x13 returns the word at 0x10.
//  4. en=0 for 5 cycles after a read of 0xCAFEF00D -> rdata stays 0xCAFEF00D; no RAM change.
//  5. DSRAM_WAIT_EN, WAIT_CYCLES=2: read held 4 cycles -> stallreq 1,1,1,0.
//     rdata valid from the DONE cycle; the next request accepted only from IDLE.
//  6. DSRAM_WAIT_EN: rst during WAIT of store to 0x20 -> word 0x20 unchanged, rdata=0, stallreq=0 next cycle.

Source files
------------

// File: rtl/dsram_pkg.sv
// Package dsram_pkg
//   Shared definitions for the data-SRAM responder:
//     dsram_state_e : wait-state engine states (ST_IDLE, ST_WAIT, ST_DONE)
//     BYTE_W        : width of one byte lane
//     WEN_READ      : byte-enable code that denotes a load
package dsram_pkg;

  localparam int BYTE_W = 8;
  localparam logic [3:0] WEN_READ = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dsram_state_e;

endpackage

// File: rtl/dsram_byte_lane.sv
// Module dsram_byte_lane
//   One byte lane of the data SRAM: BYTE_W bits x 2**ADDR_W words,
//   synchronous write, registered read.
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset (clears dout only; array not reset)
//   we   : write enable, din stored at mem[addr]
//   re   : read enable, dout <= mem[addr]; dout holds otherwise
//   addr : word index
//   din  : write byte
//   dout : registered read byte
module dsram_byte_lane
  import dsram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] dout_reg;

  // Array write kept in its own process with no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Output register with synchronous reset (the RAM output-register reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg <= '0;
    end else if (re) begin
      dout_reg <= mem[addr];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/data_sram_resp.sv
// Module data_sram_resp
//   Responder end of the CPU data-SRAM port. Serves loads/stores from EX and
//   returns the full aligned word; MEM does the lane select and extension.
//   Four dsram_byte_lane instances form a word-organised byte-write RAM.
// Configuration
//   DSRAM_WAIT_EN : when defined, a wait-state engine (IDLE/WAIT/DONE) holds
//                   the pipeline via stallreq for WAIT_CYCLES+1 cycles per
//                   access and performs the latched access at the end of the
//                   last WAIT cycle. When undefined, accesses complete on the
//                   edge ending the request cycle and stallreq is 0.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   data_sram_en    : access request
//   data_sram_wen   : byte write enables, 4'b0000 = load
//   data_sram_addr  : byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata : lane-aligned store data
//   data_sram_rdata : registered load word, held until the next load
//   stallreq        : hold-pipeline request
module data_sram_resp
  import dsram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  logic [ADDR_W-1:0] live_idx;
  assign live_idx = data_sram_addr[ADDR_W+1:2];

  // Low byte-offset bits and bits above the index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_sram_addr;

  // The access actually presented to the RAM this cycle.
  logic              acc_go;
  logic [3:0]        acc_wen;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;

`ifdef DSRAM_WAIT_EN

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  dsram_state_e      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]        wen_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [31:0]       wdata_reg;
  logic              stall_next;
  logic              go_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wen_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Capture the request once; later bus values are not used.
      if (state_reg == ST_IDLE && data_sram_en) begin
        wen_reg   <= data_sram_wen;
        idx_reg   <= live_idx;
        wdata_reg <= data_sram_wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    go_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (data_sram_en) begin
          stall_next = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_next = 1'b1;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          go_next    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Pipeline releases the held request here; en is ignored.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign stallreq  = stall_next;
  assign acc_go    = go_next;
  assign acc_wen   = wen_reg;
  assign acc_idx   = idx_reg;
  assign acc_wdata = wdata_reg;

`else

  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES > 0);

  assign stallreq  = 1'b0;
  assign acc_go    = data_sram_en;
  assign acc_wen   = data_sram_wen;
  assign acc_idx   = live_idx;
  assign acc_wdata = data_sram_wdata;

`endif

  // A load updates every lane's output register; a store leaves them alone.
  logic acc_read;
  assign acc_read = acc_go && (acc_wen == WEN_READ);

  logic [3:0]  lane_we;
  logic [31:0] lane_dout;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // Reset wins over a pending access: no write lands on a reset edge.
      assign lane_we[gi] = acc_go && acc_wen[gi] && !rst;

      dsram_byte_lane #(
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clk  (clk),
        .rst  (rst),
        .we   (lane_we[gi]),
        .re   (acc_read),
        .addr (acc_idx),
        .din  (acc_wdata[gi*BYTE_W +: BYTE_W]),
        .dout (lane_dout[gi*BYTE_W +: BYTE_W])
      );
    end
  endgenerate

  assign data_sram_rdata = lane_dout;

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp: directed scenarios plus randomized accesses
// checked against a word-array reference model. Covers both build modes.
module tb_data_sram_resp;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH       = 2 ** ADDR_W;

`ifdef DSRAM_WAIT_EN
  localparam int EXP_STALL = WAIT_CYCLES + 1;
`else
  localparam int EXP_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stallreq;

  always #5 clk = ~clk;

  data_sram_resp #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .stallreq        (stallreq)
  );

  // Reference model: memory as an array of words, plus the last loaded word.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One access through the port; holds en until stallreq drops.
  task automatic do_access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int stalls;
    int k;
    bit done;
    @(negedge clk);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #1;
    stalls = stallreq ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (stallreq) stalls++;
      else done = 1'b1;
    end
    en = 1'b0; wen = 4'h0; addr = $urandom; wdata = $urandom;
    if (!done) check("stall_timeout", 32'(stalls), 32'(EXP_STALL));
    k = word_of(a);
    if (w == 4'b0000) begin
      model_rdata = model_mem[k];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) model_mem[k][8*b +: 8] = d[8*b +: 8];
    end
    check("stall_cycles", 32'(stalls), 32'(EXP_STALL));
    check(w == 4'b0000 ? "load_data" : "store_hold", rdata, model_rdata);
    $display("txn wen=%b addr=%08h wdata=%08h rdata=%08h stalls=%0d",
             w, a, d, rdata, stalls);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_stall", {31'b0, stallreq}, 32'h0);
    rst = 1'b0;

    // Known contents for the words the random phase touches.
    for (int i = 0; i < 32; i++) do_access(4'b1111, 32'(i * 4), $urandom);

    // Full store then load.
    do_access(4'b1111, 32'h10, 32'hA1B2C3D4);
    do_access(4'b0000, 32'h10, 32'h0);
    check("t1_store_load", rdata, 32'hA1B2C3D4);

    // Single-lane store.
    do_access(4'b0100, 32'h12, 32'h00EE0000);
    do_access(4'b0000, 32'h10, 32'h0);
    check("t2_partial", rdata, 32'hA1EEC3D4);

    // Address wrap and ignored byte offset.
    do_access(4'b1111, 32'h1000, 32'h5);
    do_access(4'b0000, 32'h0000, 32'h0);
    check("t3_wrap", rdata, 32'h00000005);
    do_access(4'b0000, 32'h13, 32'h0);
    check("t3_offset", rdata, 32'hA1EEC3D4);

    // Idle bus holds the loaded word.
    do_access(4'b1111, 32'h40, 32'hCAFEF00D);
    do_access(4'b0000, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_idle_hold", rdata, 32'hCAFEF00D);
    end
    do_access(4'b0000, 32'h40, 32'h0);
    check("t4_no_change", rdata, 32'hCAFEF00D);

`ifdef DSRAM_WAIT_EN
    // Reset in the middle of a store's wait period.
    do_access(4'b1111, 32'h20, 32'h13572468);
    do_access(4'b0000, 32'h04, 32'h0);
    @(negedge clk);
    en = 1'b1; wen = 4'b1111; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("t6_in_wait", {31'b0, stallreq}, 32'h1);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; wen = 4'h0;
    @(posedge clk); #1;
    check("t6_rst_stall", {31'b0, stallreq}, 32'h0);
    check("t6_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    do_access(4'b0000, 32'h20, 32'h0);
    check("t6_word_kept", rdata, 32'h13572468);
`endif

    // Randomized accesses over the initialised window with random high bits.
    for (int n = 0; n < 150; n++) begin
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
      d = $urandom;
      w = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      do_access(w, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
